// File: rtl/cpu15_pkg.sv
// cpu15_pkg: shared state encoding and constants for the cpu15 sequencer and decoder
package cpu15_pkg;
  localparam int CPU15_PC_W = 8;
  localparam logic [3:0] OP_HALT = 4'b1111;
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WBACK  = 3'd4,
    S_HALT   = 3'd5,
    S_PAUSE  = 3'd6
  } state_t;
endpackage

// File: rtl/cpu15_sequencer_if.sv
// cpu15_sequencer_if: control/status bundle between the datapath (master) and the sequencer (slave); STEP exists only with CPU15_SEQ_STEP_EN
interface cpu15_sequencer_if #(parameter int PC_W = 8);
  logic            RUN;
  logic            STALL;
  logic            JUMP_EN;
  logic [PC_W-1:0] JUMP_ADDR;
  logic            HALT_REQ;
  logic            EN_FT;
  logic            EN_DC;
  logic            EN_EX;
  logic            EN_WB;
  logic [PC_W-1:0] P_COUNT;
  logic            RUNNING;
  logic            HALTED;
`ifdef CPU15_SEQ_STEP_EN
  logic            STEP;
  modport master(output RUN, STALL, JUMP_EN, JUMP_ADDR, HALT_REQ, STEP,
                 input EN_FT, EN_DC, EN_EX, EN_WB, P_COUNT, RUNNING, HALTED);
  modport slave(input RUN, STALL, JUMP_EN, JUMP_ADDR, HALT_REQ, STEP,
                output EN_FT, EN_DC, EN_EX, EN_WB, P_COUNT, RUNNING, HALTED);
`else
  modport master(output RUN, STALL, JUMP_EN, JUMP_ADDR, HALT_REQ,
                 input EN_FT, EN_DC, EN_EX, EN_WB, P_COUNT, RUNNING, HALTED);
  modport slave(input RUN, STALL, JUMP_EN, JUMP_ADDR, HALT_REQ,
                output EN_FT, EN_DC, EN_EX, EN_WB, P_COUNT, RUNNING, HALTED);
`endif
endinterface

// File: rtl/cpu15_pc.sv
// cpu15_pc: program counter; loads the jump target or increments on a WBACK strobe, holds otherwise or on halt
module cpu15_pc #(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            CLK,
  input  logic            RESET_N,
  input  logic            i_wb,
  input  logic            i_halt,
  input  logic            i_jump_en,
  input  logic [PC_W-1:0] i_jump_addr,
  output logic [PC_W-1:0] o_pc
);
  logic [PC_W-1:0] r_pc;
  // update only when leaving WBACK without halting; increment wraps naturally
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) r_pc <= RESET_PC;
    else if (i_wb && !i_halt) r_pc <= i_jump_en ? i_jump_addr : r_pc + PC_W'(1);
  end
  assign o_pc = r_pc;
endmodule

// File: rtl/cpu15_sequencer.sv
// cpu15_sequencer: fetch/decode/execute/writeback stepper with jump, halt and execute stall; CPU15_SEQ_STEP_EN adds a STEP-gated PAUSE after writeback
module cpu15_sequencer
  import cpu15_pkg::*;
#(
  parameter int              PC_W     = CPU15_PC_W,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input logic CLK,
  input logic RESET_N,
  cpu15_sequencer_if.slave bus
);
  state_t r_state;
  state_t w_next;
  logic   w_wb;
  assign w_wb = (r_state == S_WBACK);
  cpu15_pc #(.PC_W(PC_W), .RESET_PC(RESET_PC)) u_pc (
    .CLK        (CLK),
    .RESET_N    (RESET_N),
    .i_wb       (w_wb),
    .i_halt     (bus.HALT_REQ),
    .i_jump_en  (bus.JUMP_EN),
    .i_jump_addr(bus.JUMP_ADDR),
    .o_pc       (bus.P_COUNT)
  );
  // state register; async reset aborts any instruction in flight
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) r_state <= S_IDLE;
    else r_state <= w_next;
  end
  // next state; HALT is sticky and only reset leaves it
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   w_next = bus.RUN ? S_FETCH : S_IDLE;
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: w_next = S_EXEC;
      S_EXEC:   w_next = bus.STALL ? S_EXEC : S_WBACK;
`ifdef CPU15_SEQ_STEP_EN
      S_WBACK:  w_next = bus.HALT_REQ ? S_HALT : S_PAUSE;
      S_PAUSE:  w_next = bus.STEP ? S_FETCH : S_PAUSE;
`else
      S_WBACK:  w_next = bus.HALT_REQ ? S_HALT : S_FETCH;
`endif
      S_HALT:   w_next = S_HALT;
      default:  w_next = S_IDLE;
    endcase
  end
  // Moore outputs decoded from the state register; one enable per stage
  always_comb begin
    bus.EN_FT   = (r_state == S_FETCH);
    bus.EN_DC   = (r_state == S_DECODE);
    bus.EN_EX   = (r_state == S_EXEC);
    bus.EN_WB   = (r_state == S_WBACK);
    bus.HALTED  = (r_state == S_HALT);
    bus.RUNNING = (r_state == S_FETCH) || (r_state == S_DECODE) || (r_state == S_EXEC) ||
                  (r_state == S_WBACK) || (r_state == S_PAUSE);
  end
endmodule

// File: tb/tb_cpu15_sequencer.sv
// tb_cpu15_sequencer: table-driven check of the cpu15 sequencer plus hand-written reset sequences
module tb_cpu15_sequencer;
  logic CLK = 1'b0;
  logic RESET_N = 1'b0;
  int checks = 0;
  int failures = 0;
  cpu15_sequencer_if #(.PC_W(8)) bus ();
  cpu15_sequencer #(.PC_W(8), .RESET_PC(8'h00)) dut (.CLK(CLK), .RESET_N(RESET_N), .bus(bus));
  always #5 CLK = ~CLK;

  typedef struct {
    logic       run;
    logic       stall;
    logic       jen;
    logic [7:0] jaddr;
    logic       hreq;
    logic [3:0] en;
    logic [7:0] pc;
    logic       running;
    logic       halted;
  } vec_t;
  vec_t v[30];

  function automatic vec_t mk(logic run, logic stall, logic jen, logic [7:0] jaddr, logic hreq,
                              logic [3:0] en, logic [7:0] pc, logic running, logic halted);
    vec_t r;
    r.run = run; r.stall = stall; r.jen = jen; r.jaddr = jaddr; r.hreq = hreq;
    r.en = en; r.pc = pc; r.running = running; r.halted = halted;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic run, input logic stall, input logic jen, input logic [7:0] jaddr,
                       input logic hreq);
    bus.RUN = run; bus.STALL = stall; bus.JUMP_EN = jen; bus.JUMP_ADDR = jaddr; bus.HALT_REQ = hreq;
  endtask

  task automatic step(input logic run, input logic stall, input logic jen, input logic [7:0] jaddr,
                      input logic hreq);
    drive(run, stall, jen, jaddr, hreq);
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [3:0] ens();
    return {bus.EN_FT, bus.EN_DC, bus.EN_EX, bus.EN_WB};
  endfunction

  initial begin
    // FT=8 DC=4 EX=2 WB=1
    v[0]  = mk(1, 0, 0, 8'h00, 0, 4'h8, 8'h00, 1, 0);
    v[1]  = mk(0, 0, 1, 8'h00, 0, 4'h4, 8'h00, 1, 0);
    v[2]  = mk(0, 0, 1, 8'h55, 0, 4'h2, 8'h00, 1, 0);
    v[3]  = mk(0, 1, 0, 8'h00, 0, 4'h2, 8'h00, 1, 0);
    v[4]  = mk(0, 1, 0, 8'h00, 0, 4'h2, 8'h00, 1, 0);
    v[5]  = mk(0, 1, 0, 8'h00, 0, 4'h2, 8'h00, 1, 0);
    v[6]  = mk(0, 0, 0, 8'h00, 0, 4'h1, 8'h00, 1, 0);
    v[7]  = mk(0, 0, 0, 8'h00, 0, 4'h8, 8'h01, 1, 0);
    v[8]  = mk(1, 0, 0, 8'h00, 0, 4'h4, 8'h01, 1, 0);
    v[9]  = mk(0, 0, 0, 8'h00, 0, 4'h2, 8'h01, 1, 0);
    v[10] = mk(0, 0, 0, 8'h00, 0, 4'h1, 8'h01, 1, 0);
    v[11] = mk(0, 0, 1, 8'h08, 0, 4'h8, 8'h08, 1, 0);
    v[12] = mk(0, 0, 0, 8'h00, 0, 4'h4, 8'h08, 1, 0);
    v[13] = mk(0, 0, 0, 8'h00, 1, 4'h2, 8'h08, 1, 0);
    v[14] = mk(0, 0, 0, 8'h00, 0, 4'h1, 8'h08, 1, 0);
    v[15] = mk(0, 0, 1, 8'hFF, 0, 4'h8, 8'hFF, 1, 0);
    v[16] = mk(0, 0, 0, 8'h00, 0, 4'h4, 8'hFF, 1, 0);
    v[17] = mk(0, 0, 0, 8'h00, 0, 4'h2, 8'hFF, 1, 0);
    v[18] = mk(0, 0, 0, 8'h00, 0, 4'h1, 8'hFF, 1, 0);
    v[19] = mk(0, 0, 0, 8'h00, 0, 4'h8, 8'h00, 1, 0);
    v[20] = mk(0, 0, 0, 8'h00, 0, 4'h4, 8'h00, 1, 0);
    v[21] = mk(0, 0, 0, 8'h00, 0, 4'h2, 8'h00, 1, 0);
    v[22] = mk(0, 0, 0, 8'h00, 0, 4'h1, 8'h00, 1, 0);
    v[23] = mk(0, 0, 1, 8'h0E, 0, 4'h8, 8'h0E, 1, 0);
    v[24] = mk(0, 0, 0, 8'h00, 0, 4'h4, 8'h0E, 1, 0);
    v[25] = mk(0, 0, 0, 8'h00, 0, 4'h2, 8'h0E, 1, 0);
    v[26] = mk(0, 0, 0, 8'h00, 0, 4'h1, 8'h0E, 1, 0);
    v[27] = mk(0, 0, 1, 8'h33, 1, 4'h0, 8'h0E, 0, 1);
    v[28] = mk(1, 0, 0, 8'h00, 0, 4'h0, 8'h0E, 0, 1);
    v[29] = mk(1, 1, 0, 8'h00, 0, 4'h0, 8'h0E, 0, 1);

    drive(0, 0, 0, 8'h00, 0);
    #12;
    chk("reset_en", 32'(ens()), 32'h0);
    chk("reset_pc", 32'(bus.P_COUNT), 32'h00);
    chk("reset_running", 32'(bus.RUNNING), 32'h0);
    chk("reset_halted", 32'(bus.HALTED), 32'h0);
    @(negedge CLK);
    RESET_N = 1'b1;
    step(0, 0, 0, 8'h00, 0);
    chk("idle_hold_en", 32'(ens()), 32'h0);

    for (int i = 0; i < 30; i++) begin
      step(v[i].run, v[i].stall, v[i].jen, v[i].jaddr, v[i].hreq);
      chk($sformatf("row%0d_en", i), 32'(ens()), 32'(v[i].en));
      chk($sformatf("row%0d_pc", i), 32'(bus.P_COUNT), 32'(v[i].pc));
      chk($sformatf("row%0d_running", i), 32'(bus.RUNNING), 32'(v[i].running));
      chk($sformatf("row%0d_halted", i), 32'(bus.HALTED), 32'(v[i].halted));
      chk($sformatf("row%0d_onehot", i), 32'($countones(ens()) <= 1), 32'h1);
    end

    // leave HALT only through reset
    drive(0, 0, 0, 8'h00, 0);
    #2 RESET_N = 1'b0;
    #1;
    chk("halt_reset_halted", 32'(bus.HALTED), 32'h0);
    chk("halt_reset_pc", 32'(bus.P_COUNT), 32'h00);
    @(negedge CLK);
    RESET_N = 1'b1;

    // async reset in the middle of an EXEC cycle of the second instruction
    step(1, 0, 0, 8'h00, 0);
    chk("restart_ft", 32'(ens()), 32'h8);
    step(0, 0, 0, 8'h00, 0);
    step(0, 0, 0, 8'h00, 0);
    step(0, 0, 0, 8'h00, 0);
    step(0, 0, 0, 8'h00, 0);
    chk("second_ft_pc", 32'(bus.P_COUNT), 32'h01);
    step(0, 0, 0, 8'h00, 0);
    step(0, 1, 0, 8'h00, 0);
    chk("pre_abort_ex", 32'(ens()), 32'h2);
    #3 RESET_N = 1'b0;
    #1;
    chk("abort_en", 32'(ens()), 32'h0);
    chk("abort_running", 32'(bus.RUNNING), 32'h0);
    chk("abort_pc", 32'(bus.P_COUNT), 32'h00);
    @(negedge CLK);
    RESET_N = 1'b1;
    step(0, 0, 0, 8'h00, 0);
    chk("post_abort_idle", 32'(ens()), 32'h0);
    step(1, 0, 0, 8'h00, 0);
    chk("post_abort_ft", 32'(ens()), 32'h8);
    chk("post_abort_pc", 32'(bus.P_COUNT), 32'h00);
    chk("post_abort_running", 32'(bus.RUNNING), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
